dw_timer_responder: RTL

DW_TIMER_RESPONDER -- requirements
Module: dw_timer_responder

---
 rtl/dw_timer_responder.sv | 142 ++++++++++++++
 1 files changed

// File: rtl/dw_timer_responder.sv
// Memory-mapped 64-bit timer on the data bus: CTRL/COUNT/COMPARE/STATUS in a 32-byte window.
// Optional macro TIMER_IRQ_EN adds the registered oIRQ output and CTRL bit2 (IRQ enable).
module dw_timer_responder #(
  parameter logic [63:0] BASE_ADDR = 64'h0000_0000_FF20_0000,
  parameter int unsigned PRESC     = 50
) (
  input  logic        iCLK,
  input  logic        iRST,
  input  logic [63:0] DwAddress,
  input  logic        DwReadEnable,
  input  logic        DwWriteEnable,
  input  logic [3:0]  DwByteEnable,
  input  logic [63:0] DwWriteData,
  output logic [63:0] DwReadData
`ifdef TIMER_IRQ_EN
  ,
  output logic        oIRQ
`endif
);

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_HALT} state_e;

  localparam logic [15:0] PRESC_MAX = 16'(PRESC - 1);
`ifdef TIMER_IRQ_EN
  localparam logic [63:0] CTRL_MASK = 64'h7;
`else
  localparam logic [63:0] CTRL_MASK = 64'h3;
`endif

  state_e      state_q;
  logic [15:0] presc_q;
  logic [63:0] ctrl_q, ctrl_d;
  logic [63:0] count_q, count_d;
  logic [63:0] compare_q, compare_d;
  logic        match_q, match_d;

  logic        sel;
  logic [1:0]  off;
  logic        wr_ctrl, wr_count, wr_cmp, wr_status;
  logic        tick, hit;
  logic        unused_addr;

  assign sel         = (DwAddress[63:5] == BASE_ADDR[63:5]);
  assign off         = DwAddress[4:3];
  assign unused_addr = ^DwAddress[2:0];

  assign wr_ctrl   = sel && DwWriteEnable && (off == 2'd0);
  assign wr_count  = sel && DwWriteEnable && (off == 2'd1);
  assign wr_cmp    = sel && DwWriteEnable && (off == 2'd2);
  assign wr_status = sel && DwWriteEnable && (off == 2'd3);

  function automatic logic [63:0] merge16(input logic [63:0] old, input logic [63:0] wd,
                                          input logic [3:0] be);
    logic [63:0] r;
    for (int k = 0; k < 4; k++) r[16*k +: 16] = be[k] ? wd[16*k +: 16] : old[16*k +: 16];
    return r;
  endfunction

  // A COUNT write suppresses a coincident tick entirely, including its match.
  assign tick = (state_q == S_RUN) && ctrl_q[0] && !wr_count && (presc_q == PRESC_MAX);
  assign hit  = (count_q + 64'd1) == compare_q;

  always_comb begin
    ctrl_d    = wr_ctrl ? (merge16(ctrl_q, DwWriteData, DwByteEnable) & CTRL_MASK) : ctrl_q;
    compare_d = wr_cmp ? merge16(compare_q, DwWriteData, DwByteEnable) : compare_q;
    count_d   = count_q;
    if (wr_count)  count_d = merge16(count_q, DwWriteData, DwByteEnable);
    else if (tick) count_d = hit ? (ctrl_q[1] ? 64'd0 : compare_q) : count_q + 64'd1;
    match_d = match_q;
    if (tick && hit) match_d = 1'b1;
    else if (wr_status && DwByteEnable[0] && DwWriteData[0]) match_d = 1'b0;
  end

  always_ff @(posedge iCLK or negedge iRST) begin
    if (!iRST) begin
      state_q   <= S_IDLE;
      presc_q   <= '0;
      ctrl_q    <= '0;
      count_q   <= '0;
      compare_q <= '0;
      match_q   <= 1'b0;
    end else begin
      ctrl_q    <= ctrl_d;
      count_q   <= count_d;
      compare_q <= compare_d;
      match_q   <= match_d;
      case (state_q)
        S_IDLE: begin
          presc_q <= '0;
          if (ctrl_q[0]) state_q <= S_RUN;
        end
        S_RUN: begin
          if (!ctrl_q[0]) begin
            state_q <= S_IDLE;
            presc_q <= '0;
          end else if (wr_count || presc_q == PRESC_MAX) begin
            presc_q <= '0;
            if (tick && hit && !ctrl_q[1]) state_q <= S_HALT;
          end else begin
            presc_q <= presc_q + 16'd1;
          end
        end
        S_HALT: begin
          if (!ctrl_q[0]) begin
            state_q <= S_IDLE;
            presc_q <= '0;
          end else if (wr_count) begin
            state_q <= S_RUN;
            presc_q <= '0;
          end
        end
        default: begin
          state_q <= S_IDLE;
          presc_q <= '0;
        end
      endcase
    end
  end

`ifdef TIMER_IRQ_EN
  logic irq_q;
  always_ff @(posedge iCLK or negedge iRST) begin
    if (!iRST) irq_q <= 1'b0;
    else       irq_q <= match_q && ctrl_q[2];
  end
  assign oIRQ = irq_q;
`endif

  // Zero when unselected so several responders can be OR-ed onto one bus.
  always_comb begin
    DwReadData = 64'd0;
    if (iRST && sel && DwReadEnable) begin
      case (off)
        2'd0:    DwReadData = ctrl_q;
        2'd1:    DwReadData = count_q;
        2'd2:    DwReadData = compare_q;
        default: DwReadData = {63'd0, match_q};
      endcase
    end
  end

endmodule
